sine_table_loader: RTL and testbench

Boot-time writer for the sine quarter-wave table that the waveform generator stage reads: 16384 entries x 15 bits, indexed by the 14-bit phase argument. Accepts a stream of 16-bit words from the host-interface front end over a valid/ready handshake. Each word is written to the table RAM write port in ascending address order. Reports progress, completion, a running checksum and format errors. While loading, o_Loading gates the voice pipeline so table reads return don't-care data.

---
 rtl/sine_table_loader.sv | 121 ++++++++++++
 tb/tb_sine_table_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sine_table_loader.sv
// Boot-time loader for the sine quarter-wave table: streams host words into the
// table RAM write port in ascending address order, tracking checksum and format errors.
module sine_table_loader #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 15
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic                  i_Start,
    input  logic                  i_Valid,
    input  logic [15:0]           i_Data,
    output logic                  o_Ready,
    output logic                  o_WriteEnable,
    output logic [ADDR_WIDTH-1:0] o_WriteAddress,
    output logic [DATA_WIDTH-1:0] o_WriteData,
    output logic                  o_Loading,
    output logic                  o_Done,
    output logic                  o_Error,
    output logic [15:0]           o_Checksum
);

    localparam int unsigned CHECKSUM_WIDTH = 16;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } loaderState_t;

    loaderState_t state;
    loaderState_t nextState;

    logic [ADDR_WIDTH-1:0] counter;
    logic                  goodBeat;
    logic                  badBeat;

    // State register
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; i_Start outranks any beat presented in the same cycle
    always_comb begin
        nextState = state;
        goodBeat  = 1'b0;
        badBeat   = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (i_Start) begin
                    nextState = LOAD;
                end
            end
            LOAD: begin
                if (!i_Start && i_Valid) begin
                    if (i_Data[15]) begin
                        badBeat   = 1'b1;
                        nextState = ERROR;
                    end else begin
                        goodBeat = 1'b1;
                        if (counter == LAST_ADDR) begin
                            nextState = DONE;
                        end
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Status flags registered from the next state so they track the state register exactly
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Ready   <= 1'b0;
            o_Loading <= 1'b0;
            o_Done    <= 1'b0;
            o_Error   <= 1'b0;
        end else begin
            o_Ready   <= (nextState == LOAD);
            o_Loading <= (nextState == LOAD);
            o_Done    <= (nextState == DONE);
            o_Error   <= (nextState == ERROR);
        end
    end

    // Write port, address counter and running checksum
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_WriteEnable  <= 1'b0;
            o_WriteAddress <= '0;
            o_WriteData    <= '0;
            o_Checksum     <= '0;
            counter        <= '0;
        end else begin
            o_WriteEnable <= 1'b0;
            if (i_Start) begin
                counter    <= '0;
                o_Checksum <= '0;
            end else if (goodBeat) begin
                o_WriteEnable  <= 1'b1;
                o_WriteAddress <= counter;
                o_WriteData    <= i_Data[DATA_WIDTH-1:0];
                o_Checksum     <= o_Checksum + CHECKSUM_WIDTH'(i_Data[DATA_WIDTH-1:0]);
                // Park on the last address instead of wrapping into a second pass
                if (counter != LAST_ADDR) begin
                    counter <= counter + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // A malformed word is dropped; counter holds so the failing address stays visible
    logic unusedBadBeat;
    assign unusedBadBeat = badBeat;

endmodule

// File: tb/tb_sine_table_loader.sv
// Directed bench for sine_table_loader: full loads, throttled load, format error,
// mid-load restart, DONE hold and asynchronous reset.
module tb_sine_table_loader;

    logic        i_Clock = 1'b0;
    logic        i_Reset_n;
    logic        i_Start;
    logic        i_Valid;
    logic [15:0] i_Data;
    logic        o_Ready;
    logic        o_WriteEnable;
    logic [13:0] o_WriteAddress;
    logic [14:0] o_WriteData;
    logic        o_Loading;
    logic        o_Done;
    logic        o_Error;
    logic [15:0] o_Checksum;

    int checks = 0;
    int errors = 0;
    int monAddr = 0;
    int strobeCount = 0;

    sine_table_loader dut (
        .i_Clock        (i_Clock),
        .i_Reset_n      (i_Reset_n),
        .i_Start        (i_Start),
        .i_Valid        (i_Valid),
        .i_Data         (i_Data),
        .o_Ready        (o_Ready),
        .o_WriteEnable  (o_WriteEnable),
        .o_WriteAddress (o_WriteAddress),
        .o_WriteData    (o_WriteData),
        .o_Loading      (o_Loading),
        .o_Done         (o_Done),
        .o_Error        (o_Error),
        .o_Checksum     (o_Checksum)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic pulseStart();
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        monAddr = 0;
        strobeCount = 0;
    endtask

    // Every strobe must land on the next contiguous address carrying address+1
    always @(negedge i_Clock) begin
        if (o_WriteEnable === 1'b1) begin
            check("waddr", 32'(o_WriteAddress), 32'(monAddr));
            check("wdata", 32'(o_WriteData), 32'(monAddr + 1));
            monAddr++;
            strobeCount++;
        end
    end

    initial begin
        i_Reset_n = 1'b1;
        i_Start   = 1'b0;
        i_Valid   = 1'b0;
        i_Data    = 16'h0;
        #1 i_Reset_n = 1'b0;
        repeat (2) tick();
        @(negedge i_Clock);
        check("rst_ready", 32'(o_Ready), 32'd0);
        check("rst_we", 32'(o_WriteEnable), 32'd0);
        check("rst_waddr", 32'(o_WriteAddress), 32'd0);
        check("rst_wdata", 32'(o_WriteData), 32'd0);
        check("rst_flags", {29'd0, o_Loading, o_Done, o_Error}, 32'd0);
        check("rst_csum", 32'(o_Checksum), 32'd0);
        tick();
        i_Reset_n = 1'b1;
        tick();

        // Full load with valid held high
        pulseStart();
        i_Valid = 1'b1;
        for (int k = 0; k < 16384; k++) begin
            i_Data = 16'(k + 1);
            tick();
        end
        @(negedge i_Clock);
        check("full_done", 32'(o_Done), 32'd1);
        check("full_ready", 32'(o_Ready), 32'd0);
        check("full_csum", 32'(o_Checksum), 32'h2000);

        // DONE hold: words offered without i_Start are ignored
        i_Data = 16'd5;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge i_Clock);
            if (k == 0) check("full_count", 32'(strobeCount), 32'd16384);
            check("hold_ready", 32'(o_Ready), 32'd0);
            check("hold_we", 32'(o_WriteEnable), 32'd0);
            check("hold_done", 32'(o_Done), 32'd1);
        end
        check("hold_count", 32'(strobeCount), 32'd16384);
        i_Valid = 1'b0;
        tick();
        pulseStart();
        @(negedge i_Clock);
        check("hold_restart_done", 32'(o_Done), 32'd0);
        check("hold_restart_loading", 32'(o_Loading), 32'd1);

        // Throttled load, valid toggling every cycle
        tick();
        pulseStart();
        for (int k = 0; k < 16384; k++) begin
            i_Valid = 1'b1;
            i_Data  = 16'(k + 1);
            tick();
            if (k < 4) begin
                @(negedge i_Clock);
                check("tog_we_hi", 32'(o_WriteEnable), 32'd1);
            end
            i_Valid = 1'b0;
            i_Data  = 16'h8000;
            tick();
            if (k < 4) begin
                @(negedge i_Clock);
                check("tog_we_lo", 32'(o_WriteEnable), 32'd0);
            end
        end
        @(negedge i_Clock);
        check("tog_done", 32'(o_Done), 32'd1);
        check("tog_csum", 32'(o_Checksum), 32'h2000);
        check("tog_count", 32'(strobeCount), 32'd16384);

        // Malformed word at address 5
        tick();
        pulseStart();
        i_Valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_Data = 16'(k + 1);
            tick();
        end
        i_Data = 16'h8123;
        tick();
        i_Valid = 1'b0;
        @(negedge i_Clock);
        check("err_flag", 32'(o_Error), 32'd1);
        check("err_ready", 32'(o_Ready), 32'd0);
        check("err_csum", 32'(o_Checksum), 32'd15);
        tick();
        @(negedge i_Clock);
        check("err_we", 32'(o_WriteEnable), 32'd0);
        check("err_count", 32'(strobeCount), 32'd5);
        tick();
        pulseStart();
        @(negedge i_Clock);
        check("err_clear", 32'(o_Error), 32'd0);
        check("err_loading", 32'(o_Loading), 32'd1);
        check("err_csum0", 32'(o_Checksum), 32'd0);

        // Restart after 100 beats; the word sharing the restart cycle is dropped
        tick();
        i_Valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            i_Data = 16'(k + 1);
            tick();
        end
        i_Data = 16'h7FFF;
        pulseStart();
        i_Valid = 1'b0;
        @(negedge i_Clock);
        check("rs_we", 32'(o_WriteEnable), 32'd0);
        check("rs_csum", 32'(o_Checksum), 32'd0);
        i_Valid = 1'b1;
        i_Data  = 16'd1;
        tick();
        i_Valid = 1'b0;
        @(negedge i_Clock);
        check("rs_we1", 32'(o_WriteEnable), 32'd1);
        check("rs_addr0", 32'(o_WriteAddress), 32'd0);
        check("rs_csum1", 32'(o_Checksum), 32'd1);

        // Asynchronous reset while the strobe for address 300 is high
        tick();
        pulseStart();
        i_Valid = 1'b1;
        for (int k = 0; k < 301; k++) begin
            i_Data = 16'(k + 1);
            tick();
        end
        i_Valid = 1'b0;
        check("ar_pre_we", 32'(o_WriteEnable), 32'd1);
        check("ar_pre_addr", 32'(o_WriteAddress), 32'd300);
        check("ar_pre_csum", 32'(o_Checksum), 32'hB18B);
        #1 i_Reset_n = 1'b0;
        #1;
        check("ar_we", 32'(o_WriteEnable), 32'd0);
        check("ar_loading", 32'(o_Loading), 32'd0);
        check("ar_ready", 32'(o_Ready), 32'd0);
        check("ar_csum", 32'(o_Checksum), 32'd0);
        tick();
        tick();
        i_Reset_n = 1'b1;
        tick();
        tick();
        @(negedge i_Clock);
        check("ar_idle", {29'd0, o_Loading, o_Done, o_Error}, 32'd0);
        check("ar_idle_ready", 32'(o_Ready), 32'd0);
        check("ar_idle_csum", 32'(o_Checksum), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
